// File: rtl/key_mode_ctrl_pkg.sv
// Shared types and timing constants for the key mode controller.
// FSM state encoding plus 50 MHz defaults for 20 ms debounce and 1 s long press.
package key_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

  localparam int unsigned DEBOUNCE_20MS = 1_000_000;
  localparam int unsigned LONG_1S       = 50_000_000;

  function automatic logic [1:0] next_mode(input logic [1:0] m, input int unsigned mode_num);
    next_mode = (m == 2'(mode_num - 1)) ? 2'd0 : m + 2'd1;
  endfunction

endpackage

// File: rtl/key_mode_ctrl_sync.sv
// Generic 2-FF synchroniser; resets to all ones (released level for active-low pins).
module key_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Debounced push-key controller: short press steps the speed mode, long press toggles breathing.
// Long-press path is built only when KEY_LONG_PRESS_EN is defined.
module key_mode_ctrl
  import key_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MAX = DEBOUNCE_20MS,
  parameter int unsigned LONG_MAX     = LONG_1S,
  parameter int unsigned MODE_NUM     = 3
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       key_in,
  output logic [1:0] mode,
  output logic       breath_en,
  output logic       key_flag,
  output logic       long_flag
);

  if (MODE_NUM < 2 || MODE_NUM > 4 || DEBOUNCE_MAX < 2 || LONG_MAX < 2) begin : g_param_check
    $error("key_mode_ctrl: illegal parameter set");
  end

  localparam int unsigned DB_W = $clog2(DEBOUNCE_MAX);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_MAX - 1);

  logic            key_s;
  key_state_e      state_q, state_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [1:0]      mode_q, mode_d;
  logic            key_flag_q, key_flag_d;
  logic            long_done;

  key_sync #(.WIDTH(1)) u_sync (
    .clk   (sclk),
    .rst_n (s_rst_n),
    .d     (key_in),
    .q     (key_s)
  );

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_MAX);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_MAX - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              long_flag_q, long_flag_d;
  logic              be_q, be_d;

  assign long_done = long_done_q;
  assign long_flag = long_flag_q;
  assign breath_en = be_q;
`else
  assign long_done = 1'b0;
  assign long_flag = 1'b0;
  assign breath_en = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    db_d       = db_q;
    mode_d     = mode_q;
    key_flag_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_flag_d = 1'b0;
    be_d        = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          db_d    = '0;
        end
      end
      // key_s is tested before the terminal count, so an edge on that cycle is still bounce
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (db_q == DB_TERM) begin
          state_d    = DOWN;
          key_flag_d = 1'b1;
`ifdef KEY_LONG_PRESS_EN
          hold_d      = '0;
          long_done_d = 1'b0;
`endif
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      DOWN: begin
`ifdef KEY_LONG_PRESS_EN
        if (hold_q != HOLD_TERM) begin
          hold_d = hold_q + 1'b1;
        end else if (!long_done_q) begin
          long_flag_d = 1'b1;
          be_d        = !be_q;
          long_done_d = 1'b1;
        end
`endif
        if (key_s) begin
          state_d = REL_FILT;
          db_d    = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
        end else if (db_q == DB_TERM) begin
          state_d = IDLE;
          if (!long_done) mode_d = next_mode(mode_q, MODE_NUM);
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      db_q       <= '0;
      mode_q     <= '0;
      key_flag_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      hold_q      <= '0;
      long_done_q <= 1'b0;
      long_flag_q <= 1'b0;
      be_q        <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      mode_q     <= mode_d;
      key_flag_q <= key_flag_d;
`ifdef KEY_LONG_PRESS_EN
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      long_flag_q <= long_flag_d;
      be_q        <= be_d;
`endif
    end
  end

  assign mode     = mode_q;
  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Scoreboard bench for key_mode_ctrl with DEBOUNCE_MAX=10, LONG_MAX=50, MODE_NUM=3.
// Expected output events are queued by the stimulus; a negedge monitor matches them by cycle.
module tb_key_mode_ctrl;

  logic       sclk;
  logic       s_rst_n;
  logic       key_in;
  logic [1:0] mode;
  logic       breath_en;
  logic       key_flag;
  logic       long_flag;

  key_mode_ctrl #(
    .DEBOUNCE_MAX (10),
    .LONG_MAX     (50),
    .MODE_NUM     (3)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .key_in    (key_in),
    .mode      (mode),
    .breath_en (breath_en),
    .key_flag  (key_flag),
    .long_flag (long_flag)
  );

  typedef struct {
    int unsigned cyc;
    bit          kf;
    bit          lf;
    logic [1:0]  md;
    bit          be;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          mon_en = 1'b0;
  logic [1:0]  prev_mode = 2'd0;
  logic        prev_be = 1'b1;
  logic [1:0]  exp_mode = 2'd0;
  bit          exp_be = 1'b1;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (mon_en) begin
      if (key_flag || long_flag || mode != prev_mode || breath_en != prev_be) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got kf=%0b lf=%0b mode=%0d be=%0b, required no event",
                   cyc, key_flag, long_flag, mode, breath_en);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || e.kf != key_flag || e.lf != long_flag || e.md != mode || e.be != breath_en) begin
            errors++;
            $display("FAIL event cyc=%0d got kf=%0b lf=%0b mode=%0d be=%0b, required cyc=%0d kf=%0b lf=%0b mode=%0d be=%0b",
                     cyc, key_flag, long_flag, mode, breath_en, e.cyc, e.kf, e.lf, e.md, e.be);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        ev_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event at cyc=%0d got nothing, required kf=%0b lf=%0b mode=%0d be=%0b at cyc=%0d",
                 cyc, e.kf, e.lf, e.md, e.be, e.cyc);
      end
      prev_mode = mode;
      prev_be   = breath_en;
    end
  end

  task automatic push_ev(input int unsigned c, input bit kf, input bit lf, input logic [1:0] md, input bit be);
    ev_t e;
    e.cyc = c; e.kf = kf; e.lf = lf; e.md = md; e.be = be;
    sb.push_back(e);
  endtask

  task automatic check_val(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Drive key low for low_cycles; the fall is first sampled on edge s.
  task automatic press(input int unsigned low_cycles, input bit want_flag, input bit want_long);
    int unsigned s;
    @(posedge sclk); #1;
    key_in = 1'b0;
    s = cyc + 1;
    if (want_flag) push_ev(s + 12, 1'b1, 1'b0, exp_mode, exp_be);
    if (want_long) begin
      exp_be = !exp_be;
      push_ev(s + 62, 1'b0, 1'b1, exp_mode, exp_be);
    end
    repeat (low_cycles - 1) @(posedge sclk);
  endtask

  task automatic release_key(input int unsigned high_cycles, input bit want_step);
    int unsigned r;
    @(posedge sclk); #1;
    key_in = 1'b1;
    r = cyc + 1;
    if (want_step) begin
      exp_mode = (exp_mode == 2'd2) ? 2'd0 : exp_mode + 2'd1;
      push_ev(r + 12, 1'b0, 1'b0, exp_mode, exp_be);
    end
    repeat (high_cycles - 1) @(posedge sclk);
  endtask

  task automatic do_reset(input int unsigned n, output int unsigned rel);
    @(posedge sclk); #1;
    s_rst_n = 1'b0;
    if (exp_mode != 2'd0 || !exp_be) push_ev(cyc, 1'b0, 1'b0, 2'd0, 1'b1);
    exp_mode = 2'd0;
    exp_be   = 1'b1;
    #1;
    check_val("rst_mode", mode, 0);
    check_val("rst_breath_en", breath_en, 1);
    check_val("rst_key_flag", key_flag, 0);
    check_val("rst_long_flag", long_flag, 0);
    repeat (n) @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    rel = cyc + 1;
  endtask

  initial begin
    int unsigned rel;
    bit long_on;
`ifdef KEY_LONG_PRESS_EN
    long_on = 1'b1;
`else
    long_on = 1'b0;
`endif
    s_rst_n = 1'b0;
    key_in  = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    check_val("init_mode", mode, 0);
    check_val("init_breath_en", breath_en, 1);
    check_val("init_key_flag", key_flag, 0);
    check_val("init_long_flag", long_flag, 0);
    s_rst_n = 1'b1;
    mon_en  = 1'b1;

    // idle with key released
    repeat (100) @(posedge sclk);

    // glitches, including 10 low cycles where release lands on the terminal count
    press(3, 0, 0);  release_key(4, 0);
    press(5, 0, 0);  release_key(4, 0);
    press(9, 0, 0);  release_key(4, 0);
    press(10, 0, 0); release_key(20, 0);

    // clean 20-cycle press
    press(20, 1, 0); release_key(25, 1);

    // three short presses after reset: 1, 2, 0
    do_reset(3, rel);
    repeat (5) @(posedge sclk);
    press(20, 1, 0); release_key(25, 1);
    press(20, 1, 0); release_key(25, 1);
    press(20, 1, 0); release_key(25, 1);

    // release bounce returns to DOWN without a new flag
    press(20, 1, 0); release_key(5, 0);
    press(3, 0, 0);  release_key(25, 1);

    // shortest accepted press
    press(11, 1, 0); release_key(25, 1);

    // long presses: toggle breath_en twice, or step mode when the feature is absent
    press(80, 1, long_on); release_key(30, !long_on);
    press(80, 1, long_on); release_key(30, !long_on);
    if (!long_on) begin
      press(20, 1, 0); release_key(25, 1);
    end

    // reset mid-DOWN with mode=2, key held through reset release
    press(16, 1, 0);
    do_reset(3, rel);
    push_ev(rel + 12, 1'b1, 1'b0, 2'd0, 1'b1);
    repeat (20) @(posedge sclk);
    release_key(30, 1);

    repeat (40) @(posedge sclk);
    #1;
    check_val("scoreboard_drained", sb.size(), 0);
    check_val("final_mode", mode, exp_mode);
    check_val("final_breath_en", breath_en, exp_be);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
